// File: rtl/ahb_subordinate_ram.sv
`default_nettype none
// ============================================================================
// Module      : ahb_subordinate_ram
// Description : AHB-Lite subordinate backed by a flop-based word memory.
//               Decodes address-phase controls, inserts programmable wait
//               states (separately for NONSEQ and SEQ beats), performs
//               byte/halfword/word accesses with little-endian lane
//               selection, and returns a two-cycle ERROR response for
//               oversize, misaligned or out-of-range accesses.
//
// Ports       : i_hclk        bus clock, rising edge
//               i_hreset      asynchronous, active-high reset
//               i_hsel        subordinate select
//               i_haddr       byte address
//               i_htrans      IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//               i_hwrite      1 = write
//               i_hsize       W8=0, W16=1, W32=2 (larger values illegal)
//               i_hburst      burst type, not decoded
//               i_hwdata      write data (data phase)
//               i_hready      bus-level HREADY
//               o_hreadyout   subordinate ready (registered)
//               o_hresp       OKAY=0 / ERROR=1 (registered)
//               o_hrdata      read data, zero outside a read data cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_subordinate_ram #(
    parameter int DATA_WDT    = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int SEQ_WAIT    = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic                o_hreadyout,
    output logic [1:0]          o_hresp,
    output logic [DATA_WDT-1:0] o_hrdata
);

    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_lanes = DATA_WDT / 8;

    localparam logic [3:0] c_wait_ns = 4'(WAIT_STATES);
    localparam logic [3:0] c_wait_sq = 4'(SEQ_WAIT);

    localparam logic [1:0] c_resp_okay  = 2'b00;
    localparam logic [1:0] c_resp_error = 2'b01;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wait = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_err1 = 3'd3;
    localparam logic [2:0] c_st_err2 = 3'd4;

    // ------------------------------------------------------------------
    // Registered state and data-phase controls
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [3:0]          r_cnt;
    logic [c_aw-1:0]     r_addr_word;
    logic [1:0]          r_addr_lo;
    logic [1:0]          r_size;
    logic                r_write;
    logic                r_hreadyout;
    logic [1:0]          r_hresp;
    logic [DATA_WDT-1:0] r_mem [DEPTH];

    logic                w_accept;
    logic                w_can_accept;
    logic                w_take;
    logic                w_misalign;
    logic                w_oob;
    logic                w_illegal;
    logic [3:0]          w_wait_load;
    logic [2:0]          w_launch_state;
    logic [2:0]          w_state_nxt;
    logic [3:0]          w_cnt_nxt;
    logic [c_lanes-1:0]  w_be;
    logic                w_mem_we;
    logic                w_unused;

    // Burst type carries no meaning for a RAM target.
    assign w_unused = ^i_hburst;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = i_hsel & i_hready & i_htrans[1];

        // Only IDLE, DATA and ERR2 drive HREADYOUT high, so only those
        // states can legitimately see a new address phase complete.
        w_can_accept = (r_state == c_st_idle) || (r_state == c_st_data) ||
                       (r_state == c_st_err2);
        w_take = w_accept & w_can_accept;

        case (i_hsize)
            3'd1:    w_misalign = i_haddr[0];
            3'd2:    w_misalign = |i_haddr[1:0];
            default: w_misalign = 1'b0;
        endcase

        w_oob     = ({2'b00, i_haddr[31:2]} >= 32'(DEPTH));
        w_illegal = (i_hsize > 3'd2) | w_misalign | w_oob;

        w_wait_load = i_htrans[0] ? c_wait_sq : c_wait_ns;

        // Shared launch decision for IDLE, DATA (pipelined) and ERR2.
        if (!w_take) begin
            w_launch_state = c_st_idle;
        end else if (w_illegal) begin
            w_launch_state = c_st_err1;
        end else if (w_wait_load != 4'd0) begin
            w_launch_state = c_st_wait;
        end else begin
            w_launch_state = c_st_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_wait: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_data;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_st_err1: begin
                w_state_nxt = c_st_err2;
            end
            default: begin
                // IDLE, DATA, ERR2 and any unreachable code.
                w_state_nxt = w_launch_state;
                w_cnt_nxt   = (w_launch_state == c_st_wait) ?
                              (w_wait_load - 4'd1) : 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_addr_word <= '0;
            r_addr_lo   <= 2'd0;
            r_size      <= 2'd0;
            r_write     <= 1'b0;
            r_hreadyout <= 1'b1;
            r_hresp     <= c_resp_okay;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // Outputs are decoded from the next state so they leave a flop.
            r_hreadyout <= !((w_state_nxt == c_st_wait) ||
                             (w_state_nxt == c_st_err1));
            r_hresp     <= ((w_state_nxt == c_st_err1) ||
                            (w_state_nxt == c_st_err2)) ?
                           c_resp_error : c_resp_okay;
            // Legality is captured in the state itself (ERR1 vs WAIT/DATA).
            if (w_take) begin
                r_addr_word <= i_haddr[c_aw+1:2];
                r_addr_lo   <= i_haddr[1:0];
                r_size      <= i_hsize[1:0];
                r_write     <= i_hwrite;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane enables, little-endian
    // ------------------------------------------------------------------
    always_comb begin
        w_be = '0;
        case (r_size)
            2'd0: begin
                w_be[r_addr_lo] = 1'b1;
            end
            2'd1: begin
                w_be[{r_addr_lo[1], 1'b0}] = 1'b1;
                w_be[{r_addr_lo[1], 1'b1}] = 1'b1;
            end
            default: begin
                w_be = '1;
            end
        endcase
    end

    // Reset forces the FSM out of DATA asynchronously, so a write that was
    // in flight when reset hits never reaches the array.
    assign w_mem_we = (r_state == c_st_data) && r_write;

    // Memory contents deliberately survive reset.
    always_ff @(posedge i_hclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (w_be[b]) begin
                    r_mem[r_addr_word][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end

    assign o_hreadyout = r_hreadyout;
    assign o_hresp     = r_hresp;
    assign o_hrdata    = ((r_state == c_st_data) && !r_write) ?
                         r_mem[r_addr_word] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_subordinate_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_subordinate_ram
// Description : Self-checking bench for ahb_subordinate_ram. Two instances:
//               one with zero wait states, one with WAIT_STATES=2. Address
//               phases come from vector tables; expected data-phase results
//               are queued when a transfer is accepted and compared when the
//               target completes the beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_subordinate_ram;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_nseq = 2'd2;
    localparam logic [1:0] c_seq  = 2'd3;
    localparam int         c_ws_b = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [2:0]  burst;
    bit          tgt;

    logic        hsel_a, hsel_b, hready;
    logic        rdy_a, rdy_b;
    logic [1:0]  resp_a, resp_b;
    logic [31:0] rdata_a, rdata_b;

    always #5 clk = ~clk;

    assign hsel_a = sel & ~tgt;
    assign hsel_b = sel & tgt;
    assign hready = tgt ? rdy_b : rdy_a;

    ahb_subordinate_ram #(
        .DATA_WDT(32), .DEPTH(256), .WAIT_STATES(0), .SEQ_WAIT(0)
    ) u_dut_a (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel_a), .i_haddr(addr),
        .i_htrans(trans), .i_hwrite(wr), .i_hsize(size), .i_hburst(burst),
        .i_hwdata(wdata), .i_hready(hready), .o_hreadyout(rdy_a),
        .o_hresp(resp_a), .o_hrdata(rdata_a)
    );

    ahb_subordinate_ram #(
        .DATA_WDT(32), .DEPTH(256), .WAIT_STATES(c_ws_b), .SEQ_WAIT(0)
    ) u_dut_b (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel_b), .i_haddr(addr),
        .i_htrans(trans), .i_hwrite(wr), .i_hsize(size), .i_hburst(burst),
        .i_hwdata(wdata), .i_hready(hready), .o_hreadyout(rdy_b),
        .o_hresp(resp_b), .o_hrdata(rdata_b)
    );

    typedef struct {
        bit          tgt;
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        err;
        int          exp_waits;
        int          waits;
        string       name;
    } sb_t;

    sb_t         sbq[$];
    vec_t        tbl_a[$];
    vec_t        tbl_bw[$];
    vec_t        tbl_br[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_done = 0;
    int          t0;
    logic [31:0] cur_wdata;
    logic [31:0] cur_rdata;
    logic        cur_err;
    string       cur_name;

    function automatic vec_t mk(bit t, logic s, logic [1:0] tr, logic w,
                                logic [2:0] sz, logic [31:0] a,
                                logic [31:0] d, logic [31:0] r, logic e,
                                string n);
        vec_t v;
        v.tgt = t; v.sel = s; v.trans = tr; v.write = w; v.size = sz;
        v.addr = a; v.wdata = d; v.rdata = r; v.err = e; v.name = n;
        return v;
    endfunction

    function automatic logic obs_rdy();
        return tgt ? rdy_b : rdy_a;
    endfunction

    function automatic logic [1:0] obs_resp();
        return tgt ? resp_b : resp_a;
    endfunction

    function automatic logic [31:0] obs_rdata();
        return tgt ? rdata_b : rdata_a;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Evaluate the current cycle, then advance one clock.
    task automatic step();
        sb_t e;
        if (sbq.size() > 0) begin
            if (!obs_rdy()) begin
                sbq[0].waits = sbq[0].waits + 1;
                chk({sbq[0].name, "_stall_resp"}, 32'(obs_resp()),
                    sbq[0].err ? 32'd1 : 32'd0);
            end else begin
                chk({sbq[0].name, "_resp"}, 32'(obs_resp()),
                    sbq[0].err ? 32'd1 : 32'd0);
                if (!sbq[0].write && !sbq[0].err)
                    chk({sbq[0].name, "_rdata"}, obs_rdata(), sbq[0].exp_rdata);
                chk({sbq[0].name, "_waits"}, 32'(sbq[0].waits),
                    32'(sbq[0].exp_waits));
                last_done = cyc;
                void'(sbq.pop_front());
            end
        end else begin
            chk("idle_ready", 32'(obs_rdy()), 32'd1);
            chk("idle_resp", 32'(obs_resp()), 32'd0);
            chk("idle_rdata", obs_rdata(), 32'd0);
        end
        if (sel && obs_rdy() && trans[1]) begin
            e.write     = wr;
            e.wdata     = cur_wdata;
            e.exp_rdata = cur_rdata;
            e.err       = cur_err;
            e.exp_waits = cur_err ? 1 :
                          ((trans == c_seq) ? 0 : (tgt ? c_ws_b : 0));
            e.waits     = 0;
            e.name      = cur_name;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        wdata = (sbq.size() > 0 && sbq[0].write) ? sbq[0].wdata : 32'h0;
    endtask

    task automatic drive(vec_t v);
        tgt = v.tgt; sel = v.sel; trans = v.trans; wr = v.write;
        size = v.size; addr = v.addr;
        cur_wdata = v.wdata; cur_rdata = v.rdata; cur_err = v.err;
        cur_name = v.name;
    endtask

    // Hold the address phase until it is accepted (bounded).
    task automatic run_vec(vec_t v);
        bit done;
        bit take;
        done = 1'b0;
        drive(v);
        for (int k = 0; k < 40 && !done; k++) begin
            take = sel && obs_rdy() && trans[1];
            step();
            if (take || !(v.sel && v.trans[1])) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_accept: not accepted within 40 cycles", v.name);
        end
    endtask

    task automatic drain();
        sel = 1'b0; trans = c_idle; wr = 1'b0;
        for (int k = 0; k < 40 && sbq.size() > 0; k++) step();
        checks++;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding beats expected 0",
                     sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; tgt = 1'b0; addr = 32'h0; trans = c_idle;
        wr = 1'b0; size = 3'd2; burst = 3'b001; wdata = 32'h0;
        cur_wdata = 32'h0; cur_rdata = 32'h0; cur_err = 1'b0; cur_name = "";

        // Zero-wait target: data path, lanes, errors, pipelining, BUSY.
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h10,32'hDEADBEEF,0,0,"wr_deadbeef"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h10,0,32'hDEADBEEF,0,"rd_deadbeef"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h10,32'h11223344,0,0,"wr_preload"));
        tbl_a.push_back(mk(0,1,c_nseq,1,0,32'h13,32'hAAFFEEDD,0,0,"wr_b3"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h10,0,32'hAA223344,0,"rd_b3"));
        tbl_a.push_back(mk(0,1,c_nseq,1,1,32'h10,32'h99885566,0,0,"wr_h0"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h10,0,32'hAA225566,0,"rd_h0"));
        tbl_a.push_back(mk(0,0,c_nseq,1,2,32'h10,32'hBAD0BAD0,0,0,"wr_unsel"));
        tbl_a.push_back(mk(0,1,c_idle,1,2,32'h10,32'hBAD1BAD1,0,0,"idle_sel"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h10,0,32'hAA225566,0,"rd_unsel"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h20,32'hCAFEF00D,0,0,"wr_hazard"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h20,0,32'hCAFEF00D,0,"rd_hazard"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h00,32'h01020304,0,0,"wr_w0"));
        tbl_a.push_back(mk(0,1,c_nseq,1,1,32'h01,32'hFFFFFFFF,0,1,"err_misalign"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h00,0,32'h01020304,0,"rd_w0_a"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h400,32'hFFFFFFFF,0,1,"err_range"));
        tbl_a.push_back(mk(0,1,c_nseq,1,3,32'h00,32'hFFFFFFFF,0,1,"err_size3"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h00,0,32'h01020304,0,"rd_w0_b"));
        tbl_a.push_back(mk(0,1,c_nseq,0,1,32'h02,0,32'h01020304,0,"rd_h1"));
        tbl_a.push_back(mk(0,1,c_nseq,0,0,32'h03,0,32'h01020304,0,"rd_b3_w0"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h30,32'h00001111,0,0,"wr_30"));
        tbl_a.push_back(mk(0,1,c_nseq,1,2,32'h34,32'h00002222,0,0,"wr_34"));
        tbl_a.push_back(mk(0,1,c_nseq,0,2,32'h30,0,32'h00001111,0,"brd_30"));
        tbl_a.push_back(mk(0,1,c_busy,0,2,32'h34,0,0,0,"brd_busy"));
        tbl_a.push_back(mk(0,1,c_seq, 0,2,32'h34,0,32'h00002222,0,"brd_34"));

        // Two-wait target: INCR4 write, then INCR4 read.
        tbl_bw.push_back(mk(1,1,c_nseq,1,2,32'h0,32'hB0B0B0B0,0,0,"bw0"));
        tbl_bw.push_back(mk(1,1,c_seq, 1,2,32'h4,32'hB1B1B1B1,0,0,"bw1"));
        tbl_bw.push_back(mk(1,1,c_seq, 1,2,32'h8,32'hB2B2B2B2,0,0,"bw2"));
        tbl_bw.push_back(mk(1,1,c_seq, 1,2,32'hC,32'hB3B3B3B3,0,0,"bw3"));
        tbl_br.push_back(mk(1,1,c_nseq,0,2,32'h0,0,32'hB0B0B0B0,0,"br0"));
        tbl_br.push_back(mk(1,1,c_seq, 0,2,32'h4,0,32'hB1B1B1B1,0,"br1"));
        tbl_br.push_back(mk(1,1,c_seq, 0,2,32'h8,0,32'hB2B2B2B2,0,"br2"));
        tbl_br.push_back(mk(1,1,c_seq, 0,2,32'hC,0,32'hB3B3B3B3,0,"br3"));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 32'(rdy_a), 32'd1);
        chk("rst_a_resp", 32'(resp_a), 32'd0);
        chk("rst_a_rdata", rdata_a, 32'd0);
        chk("rst_b_ready", 32'(rdy_b), 32'd1);
        chk("rst_b_resp", 32'(resp_b), 32'd0);
        chk("rst_b_rdata", rdata_b, 32'd0);
        rst = 1'b0;

        foreach (tbl_a[i]) run_vec(tbl_a[i]);
        drain();

        foreach (tbl_bw[i]) run_vec(tbl_bw[i]);
        drain();

        // INCR4 read: 2 waits on the NONSEQ beat, 7 cycles end to end.
        t0 = cyc;
        foreach (tbl_br[i]) run_vec(tbl_br[i]);
        drain();
        chk("incr4_span", 32'(last_done - t0), 32'd6);

        // Reset during the first WAIT cycle of a write.
        drive(mk(1,1,c_nseq,1,2,32'h0,32'h12345678,0,0,"rst_wr"));
        step();
        sel = 1'b0; trans = c_idle; wr = 1'b0;
        chk("rst_mid_stall", 32'(rdy_b), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(rdy_b), 32'd1);
        chk("rst_mid_resp", 32'(resp_b), 32'd0);
        sbq.delete();
        wdata = 32'h0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        run_vec(mk(1,1,c_nseq,0,2,32'h0,0,32'hB0B0B0B0,0,"rd_after_rst"));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
